// File: rtl/dft4_stream_pipe.sv
`default_nettype none
// ============================================================================
// Module      : dft4_stream_pipe
// Description : Streaming two-stage 4-point DFT engine. Accepts one complex
//               4-sample frame per beat on a valid/ready input and presents
//               bins X0..X3 on a valid/ready output two stages later, with
//               full backpressure and a per-frame scale mode.
//               Words are packed {real, imag}; each half is HALF = WORD_SZ/2
//               bits signed two's complement.
// Ports       : i_clk, i_rst (sync, active-high)
//               i_valid / o_ready, i_scale, i_A..i_D  : input frame x0..x3
//               o_valid / i_ready, o_A..o_D, o_ovf    : output bins X0..X3
// Config      : define DFT_SAT_EN to saturate unscaled outputs and report
//               o_ovf; otherwise unscaled outputs wrap and o_ovf is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module dft4_stream_pipe #(
    parameter int WORD_SZ = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_scale,
    input  logic [WORD_SZ-1:0] i_A,
    input  logic [WORD_SZ-1:0] i_B,
    input  logic [WORD_SZ-1:0] i_C,
    input  logic [WORD_SZ-1:0] i_D,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [WORD_SZ-1:0] o_A,
    output logic [WORD_SZ-1:0] o_B,
    output logic [WORD_SZ-1:0] o_C,
    output logic [WORD_SZ-1:0] o_D,
    output logic               o_ovf
);

    localparam int c_HALF = WORD_SZ / 2;
    localparam int c_H1   = c_HALF + 1;
    localparam int c_H2   = c_HALF + 2;

`ifdef DFT_SAT_EN
    localparam logic signed [c_H2-1:0] c_SAT_MAX = {3'b000, {(c_HALF-1){1'b1}}};
    localparam logic signed [c_H2-1:0] c_SAT_MIN = {3'b111, {(c_HALF-1){1'b0}}};
`endif

    // Sign-extend a stage-1 component to the stage-2 working width.
    function automatic logic signed [c_H2-1:0] ext(input logic signed [c_H1-1:0] v);
        return {v[c_H1-1], v};
    endfunction

    // Reduce a stage-2 component to HALF bits; MSB of the result flags saturation.
    // Scaled mode keeps bits [H2-1:2], i.e. an arithmetic shift right by two.
    function automatic logic [c_HALF:0] reduce(input logic signed [c_H2-1:0] v,
                                               input logic scale);
        logic [c_HALF:0] res;
        if (scale) begin
            res = {1'b0, v[c_H2-1:2]};
        end else begin
`ifdef DFT_SAT_EN
            if (v > c_SAT_MAX)
                res = {1'b1, c_SAT_MAX[c_HALF-1:0]};
            else if (v < c_SAT_MIN)
                res = {1'b1, c_SAT_MIN[c_HALF-1:0]};
            else
                res = {1'b0, v[c_HALF-1:0]};
`else
            res = {1'b0, v[c_HALF-1:0]};
`endif
        end
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Handshake: ready ripples back from the output; never looks at i_valid.
    // ------------------------------------------------------------------
    logic r_v1, r_v2;
    logic w_en1, w_en2;

    assign w_en2   = !r_v2 || i_ready;
    assign w_en1   = !r_v1 || w_en2;
    assign o_ready = w_en1;
    assign o_valid = r_v2;

    // ------------------------------------------------------------------
    // Stage 1: radix-2 butterflies a+-c, b+-d at HALF+1 bits
    // ------------------------------------------------------------------
    logic signed [c_HALF-1:0] w_ar, w_ai, w_br, w_bi, w_cr, w_ci, w_dr, w_di;
    assign w_ar = i_A[WORD_SZ-1:c_HALF];
    assign w_ai = i_A[c_HALF-1:0];
    assign w_br = i_B[WORD_SZ-1:c_HALF];
    assign w_bi = i_B[c_HALF-1:0];
    assign w_cr = i_C[WORD_SZ-1:c_HALF];
    assign w_ci = i_C[c_HALF-1:0];
    assign w_dr = i_D[WORD_SZ-1:c_HALF];
    assign w_di = i_D[c_HALF-1:0];

    logic signed [c_H1-1:0] r_s0r, r_s0i, r_s1r, r_s1i, r_s2r, r_s2i, r_s3r, r_s3i;
    logic                   r_scale1;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v1     <= 1'b0;
            r_scale1 <= 1'b0;
            r_s0r    <= '0;
            r_s0i    <= '0;
            r_s1r    <= '0;
            r_s1i    <= '0;
            r_s2r    <= '0;
            r_s2i    <= '0;
            r_s3r    <= '0;
            r_s3i    <= '0;
        end else if (w_en1) begin
            r_v1 <= i_valid;
            if (i_valid) begin
                r_scale1 <= i_scale;
                r_s0r    <= {w_ar[c_HALF-1], w_ar} + {w_cr[c_HALF-1], w_cr};
                r_s0i    <= {w_ai[c_HALF-1], w_ai} + {w_ci[c_HALF-1], w_ci};
                r_s1r    <= {w_ar[c_HALF-1], w_ar} - {w_cr[c_HALF-1], w_cr};
                r_s1i    <= {w_ai[c_HALF-1], w_ai} - {w_ci[c_HALF-1], w_ci};
                r_s2r    <= {w_br[c_HALF-1], w_br} + {w_dr[c_HALF-1], w_dr};
                r_s2i    <= {w_bi[c_HALF-1], w_bi} + {w_di[c_HALF-1], w_di};
                r_s3r    <= {w_br[c_HALF-1], w_br} - {w_dr[c_HALF-1], w_dr};
                r_s3i    <= {w_bi[c_HALF-1], w_bi} - {w_di[c_HALF-1], w_di};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: combine with twiddles +-1 / -j (X1) and +j (X3)
    // ------------------------------------------------------------------
    logic signed [c_H2-1:0] w_x0r, w_x0i, w_x1r, w_x1i, w_x2r, w_x2i, w_x3r, w_x3i;
    assign w_x0r = ext(r_s0r) + ext(r_s2r);
    assign w_x0i = ext(r_s0i) + ext(r_s2i);
    assign w_x2r = ext(r_s0r) - ext(r_s2r);
    assign w_x2i = ext(r_s0i) - ext(r_s2i);
    assign w_x1r = ext(r_s1r) + ext(r_s3i);
    assign w_x1i = ext(r_s1i) - ext(r_s3r);
    assign w_x3r = ext(r_s1r) - ext(r_s3i);
    assign w_x3i = ext(r_s1i) + ext(r_s3r);

    logic [c_HALF:0] w_y0r, w_y0i, w_y1r, w_y1i, w_y2r, w_y2i, w_y3r, w_y3i;
    assign w_y0r = reduce(w_x0r, r_scale1);
    assign w_y0i = reduce(w_x0i, r_scale1);
    assign w_y1r = reduce(w_x1r, r_scale1);
    assign w_y1i = reduce(w_x1i, r_scale1);
    assign w_y2r = reduce(w_x2r, r_scale1);
    assign w_y2i = reduce(w_x2i, r_scale1);
    assign w_y3r = reduce(w_x3r, r_scale1);
    assign w_y3i = reduce(w_x3i, r_scale1);

    logic w_ovf;
    assign w_ovf = w_y0r[c_HALF] | w_y0i[c_HALF] | w_y1r[c_HALF] | w_y1i[c_HALF] |
                   w_y2r[c_HALF] | w_y2i[c_HALF] | w_y3r[c_HALF] | w_y3i[c_HALF];

    // Output data only loads with a real frame so it reads 0 until the first one.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_v2  <= 1'b0;
            o_A   <= '0;
            o_B   <= '0;
            o_C   <= '0;
            o_D   <= '0;
            o_ovf <= 1'b0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                o_A   <= {w_y0r[c_HALF-1:0], w_y0i[c_HALF-1:0]};
                o_B   <= {w_y1r[c_HALF-1:0], w_y1i[c_HALF-1:0]};
                o_C   <= {w_y2r[c_HALF-1:0], w_y2i[c_HALF-1:0]};
                o_D   <= {w_y3r[c_HALF-1:0], w_y3i[c_HALF-1:0]};
                o_ovf <= w_ovf;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dft4_stream_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_dft4_stream_pipe
// Description : Directed self-checking bench for dft4_stream_pipe (WORD_SZ=16,
//               HALF=8). Expected values are hand-derived per vector.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dft4_stream_pipe;

    localparam int c_W = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid, in_ready_o, in_scale;
    logic [c_W-1:0] a, b, c, d;
    logic           out_valid, out_ready;
    logic [c_W-1:0] xa, xb, xc, xd;
    logic           ovf;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dft4_stream_pipe #(.WORD_SZ(c_W)) u_dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_valid (in_valid),
        .o_ready (in_ready_o),
        .i_scale (in_scale),
        .i_A     (a),
        .i_B     (b),
        .i_C     (c),
        .i_D     (d),
        .o_valid (out_valid),
        .i_ready (out_ready),
        .o_A     (xa),
        .o_B     (xb),
        .o_C     (xc),
        .o_D     (xd),
        .o_ovf   (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pk(input int re, input int im);
        logic [7:0] r8, i8;
        r8 = re[7:0];
        i8 = im[7:0];
        return {r8, i8};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One isolated frame: checks 2-cycle latency and the four bins.
    task automatic send_one(input string tag,
                            input logic [15:0] ia, ib, ic, id, input logic sc,
                            input logic [15:0] ea, eb, ec, ed, input logic eo);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_scale  = sc;
        a = ia; b = ib; c = ic; d = id;
        #1;
        chk({tag, "_rdy"}, in_ready_o, 1'b1);
        step();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 1'b0);
        step();
        chk({tag, "_vld"}, out_valid, 1'b1);
        chk({tag, "_X0"}, xa, ea);
        chk({tag, "_X1"}, xb, eb);
        chk({tag, "_X2"}, xc, ec);
        chk({tag, "_X3"}, xd, ed);
        chk({tag, "_ovf"}, ovf, eo);
        step();
        chk({tag, "_drain"}, out_valid, 1'b0);
    endtask

    logic [15:0] fa[8], fb[8], fc[8], fd[8];
    logic        fs[8];
    logic [15:0] ea[8], eb[8], ed[8];
    logic        eo[8];

    // Streams n frames from the tables; i_ready low on cycles slo..shi.
    task automatic run_stream(input string tag, input int n, input int slo, input int shi);
        int          sent = 0;
        int          recv = 0;
        int          infl;
        logic        hold = 1'b0;
        logic [15:0] held_a = '0;
        for (int cy = 0; cy < 60 && recv < n; cy++) begin
            out_ready = !(cy >= slo && cy <= shi);
            if (sent < n) begin
                in_valid = 1'b1;
                a = fa[sent]; b = fb[sent]; c = fc[sent]; d = fd[sent];
                in_scale = fs[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (hold) begin
                chk({tag, "_hold_vld"}, out_valid, 1'b1);
                chk({tag, "_hold_X0"}, xa, held_a);
            end
            infl = sent - recv;
            chk({tag, "_rdy"}, in_ready_o, !(infl == 2 && out_valid && !out_ready));
            hold   = out_valid && !out_ready;
            held_a = xa;
            if (out_valid && out_ready) begin
                if (recv < n) begin
                    chk({tag, "_X0"}, xa, ea[recv]);
                    chk({tag, "_X1"}, xb, eb[recv]);
                    chk({tag, "_X3"}, xd, ed[recv]);
                    chk({tag, "_ovf"}, ovf, eo[recv]);
                end
                recv++;
            end
            if (in_valid && in_ready_o) sent++;
            step();
        end
        in_valid = 1'b0;
        chk({tag, "_count"}, recv, n);
        step();
        step();
        chk({tag, "_no_dup"}, out_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_scale = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; c = '0; d = '0;
        step();
        step();
        chk("rst_vld", out_valid, 1'b0);
        chk("rst_X0", xa, 16'h0);
        chk("rst_X3", xd, 16'h0);
        chk("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_rdy", in_ready_o, 1'b1);
        step();

        send_one("dc", pk(1,0), pk(1,0), pk(1,0), pk(1,0), 1'b0,
                 pk(4,0), pk(0,0), pk(0,0), pk(0,0), 1'b0);
        send_one("imp_a", pk(1,0), 16'h0, 16'h0, 16'h0, 1'b0,
                 pk(1,0), pk(1,0), pk(1,0), pk(1,0), 1'b0);
        send_one("imp_b", 16'h0, pk(0,1), 16'h0, 16'h0, 1'b0,
                 pk(0,1), pk(1,0), pk(0,-1), pk(-1,0), 1'b0);
        send_one("scl1", pk(100,0), pk(100,0), pk(100,0), pk(100,0), 1'b1,
                 pk(100,0), 16'h0, 16'h0, 16'h0, 1'b0);
        // -3 >>> 2 = -1 (toward -inf), 5 >>> 2 = 1
        send_one("scl_neg", pk(-3,5), 16'h0, 16'h0, 16'h0, 1'b1,
                 pk(-1,1), pk(-1,1), pk(-1,1), pk(-1,1), 1'b0);
`ifdef DFT_SAT_EN
        send_one("scl0", pk(100,0), pk(100,0), pk(100,0), pk(100,0), 1'b0,
                 pk(127,0), 16'h0, 16'h0, 16'h0, 1'b1);
        send_one("scl0_neg", pk(-128,0), pk(-128,0), pk(-128,0), pk(-128,0), 1'b0,
                 pk(-128,0), 16'h0, 16'h0, 16'h0, 1'b1);
`else
        send_one("scl0", pk(100,0), pk(100,0), pk(100,0), pk(100,0), 1'b0,
                 pk(-112,0), 16'h0, 16'h0, 16'h0, 1'b0);
        send_one("scl0_neg", pk(-128,0), pk(-128,0), pk(-128,0), pk(-128,0), 1'b0,
                 pk(0,0), 16'h0, 16'h0, 16'h0, 1'b0);
`endif

        // Six frames, impulse on A, so every bin equals A.
        for (int k = 0; k < 6; k++) begin
            fa[k] = pk(k + 1, -k);
            fb[k] = '0; fc[k] = '0; fd[k] = '0; fs[k] = 1'b0;
            ea[k] = fa[k]; eb[k] = fa[k]; ed[k] = fa[k]; eo[k] = 1'b0;
        end
        run_stream("strm", 6, 3, 5);

        // Alternating scale: 1,0,1,0 on DC frames of 100,100,96,96.
        for (int k = 0; k < 4; k++) begin
            int v;
            v = (k < 2) ? 100 : 96;
            fa[k] = pk(v, 0); fb[k] = fa[k]; fc[k] = fa[k]; fd[k] = fa[k];
            fs[k] = (k % 2 == 0);
            eb[k] = '0; ed[k] = '0;
            if (fs[k]) begin
                ea[k] = pk(v, 0);
                eo[k] = 1'b0;
            end else begin
`ifdef DFT_SAT_EN
                ea[k] = pk(127, 0);
                eo[k] = 1'b1;
`else
                ea[k] = (v == 100) ? pk(-112, 0) : pk(-128, 0);
                eo[k] = 1'b0;
`endif
            end
        end
        run_stream("mix", 4, 100, 100);

        // Reset mid-flight: second frame's acceptance edge also samples reset.
        out_ready = 1'b1;
        in_valid = 1'b1; in_scale = 1'b0;
        a = pk(7,0); b = '0; c = '0; d = '0;
        step();
        a = pk(9,0);
        rst = 1'b1;
        step();
        in_valid = 1'b0;
        rst = 1'b0;
        chk("mrst_vld", out_valid, 1'b0);
        chk("mrst_X0", xa, 16'h0);
        chk("mrst_rdy", in_ready_o, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mrst_quiet", out_valid, 1'b0);
        end
        chk("mrst_X0_end", xa, 16'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
